// File: rtl/stage_sequencer.sv
// Instruction stage sequencer with multi-cycle EXECUTE, optional memory stage, bus-wait timeout,
// trap entry/return with a recorded cause, and a retired-instruction counter.
module stage_sequencer #(
  parameter int EXEC_CYCLES  = 1,
  parameter int WAIT_TIMEOUT = 255,
  parameter int CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             instruction_complete,
  input  logic             needs_mem,
  input  logic             illegal_op,
  input  logic             mem_ready,
  input  logic             ext_irq,
  input  logic             trap_return,
  output logic             instruction_fetch,
  output logic             instruction_decode,
  output logic             instruction_execute,
  output logic             memory_access,
  output logic             write_back,
  output logic             trap_mode,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] retired_count,
  output logic [2:0]       state
);

  localparam int WAIT_W = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;
  localparam int EXEC_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(WAIT_TIMEOUT);
  localparam logic [EXEC_W-1:0] EXEC_LAST  = EXEC_W'(EXEC_CYCLES - 1);
  localparam bit TIMEOUT_ON = (WAIT_TIMEOUT != 0);

  typedef enum logic [2:0] {
    FETCH         = 3'd0,
    DECODE        = 3'd1,
    EXECUTE       = 3'd2,
    MEMORY_ACCESS = 3'd3,
    WRITE_BACK    = 3'd4,
    TRAP          = 3'd5
  } state_t;

  state_t            cur;
  logic [WAIT_W-1:0] wait_cnt;
  logic [EXEC_W-1:0] exec_cnt;
  logic              mem_flag;

  // Counters default to clear so that every state change resets them; only
  // branches that stay in the same state advance them.
  always_ff @(posedge clock) begin
    if (reset) begin
      cur           <= FETCH;
      wait_cnt      <= '0;
      exec_cnt      <= '0;
      mem_flag      <= 1'b0;
      trap_cause    <= 2'd0;
      retired_count <= '0;
    end else begin
      wait_cnt <= '0;
      exec_cnt <= '0;
      case (cur)
        FETCH: begin
          if (ext_irq) begin
            cur        <= TRAP;
            trap_cause <= 2'd1;
          end else if (instruction_complete) begin
            cur <= DECODE;
          end else if (TIMEOUT_ON && wait_cnt == WAIT_LIMIT) begin
            cur        <= TRAP;
            trap_cause <= 2'd2;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        DECODE: begin
          if (illegal_op) begin
            cur        <= TRAP;
            trap_cause <= 2'd0;
          end else begin
            mem_flag <= needs_mem;
            cur      <= EXECUTE;
          end
        end
        EXECUTE: begin
          if (exec_cnt == EXEC_LAST) begin
            cur <= mem_flag ? MEMORY_ACCESS : WRITE_BACK;
          end else begin
            exec_cnt <= exec_cnt + EXEC_W'(1);
          end
        end
        MEMORY_ACCESS: begin
          if (mem_ready) begin
            cur <= WRITE_BACK;
          end else if (TIMEOUT_ON && wait_cnt == WAIT_LIMIT) begin
            cur        <= TRAP;
            trap_cause <= 2'd2;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        WRITE_BACK: begin
          retired_count <= retired_count + CNT_W'(1);
          cur           <= FETCH;
        end
        TRAP: begin
          if (trap_return) begin
            cur <= FETCH;
          end
        end
        default: begin
          cur        <= TRAP;
          trap_cause <= 2'd3;
        end
      endcase
    end
  end

  assign state               = cur;
  assign instruction_fetch   = (cur == FETCH);
  assign instruction_decode  = (cur == DECODE);
  assign instruction_execute = (cur == EXECUTE);
  assign memory_access       = (cur == MEMORY_ACCESS);
  assign write_back          = (cur == WRITE_BACK);
  assign trap_mode           = (cur == TRAP);

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: instance a (EXEC_CYCLES=1, WAIT_TIMEOUT=4, CNT_W=4) and
// instance b (EXEC_CYCLES=3, defaults otherwise) share one input set.
module tb_stage_sequencer;

  localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3, S_W = 3'd4, S_T = 3'd5;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic instruction_complete = 1'b0;
  logic needs_mem = 1'b0;
  logic illegal_op = 1'b0;
  logic mem_ready = 1'b0;
  logic ext_irq = 1'b0;
  logic trap_return = 1'b0;

  logic a_fetch, a_decode, a_execute, a_mem, a_wb, a_trap;
  logic [1:0] a_cause;
  logic [3:0] a_count;
  logic [2:0] a_state;
  logic b_fetch, b_decode, b_execute, b_mem, b_wb, b_trap;
  logic [1:0] b_cause;
  logic [15:0] b_count;
  logic [2:0] b_state;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  stage_sequencer #(.EXEC_CYCLES(1), .WAIT_TIMEOUT(4), .CNT_W(4)) dut_a (
    .clock(clock), .reset(reset), .instruction_complete(instruction_complete),
    .needs_mem(needs_mem), .illegal_op(illegal_op), .mem_ready(mem_ready),
    .ext_irq(ext_irq), .trap_return(trap_return),
    .instruction_fetch(a_fetch), .instruction_decode(a_decode),
    .instruction_execute(a_execute), .memory_access(a_mem), .write_back(a_wb),
    .trap_mode(a_trap), .trap_cause(a_cause), .retired_count(a_count), .state(a_state)
  );

  stage_sequencer #(.EXEC_CYCLES(3)) dut_b (
    .clock(clock), .reset(reset), .instruction_complete(instruction_complete),
    .needs_mem(needs_mem), .illegal_op(illegal_op), .mem_ready(mem_ready),
    .ext_irq(ext_irq), .trap_return(trap_return),
    .instruction_fetch(b_fetch), .instruction_decode(b_decode),
    .instruction_execute(b_execute), .memory_access(b_mem), .write_back(b_wb),
    .trap_mode(b_trap), .trap_cause(b_cause), .retired_count(b_count), .state(b_state)
  );

  typedef struct {
    logic rst, cmp, nm, ill, mr, irq, tr;
    logic [2:0] st;
    logic [1:0] cause;
    logic [3:0] cnt;
  } vec_t;

  // Drive one cycle of inputs, let one rising edge pass, then sample 1 ns later.
  task automatic applyStimulus(input logic rst, cmp, nm, ill, mr, irq, tr);
    reset = rst;
    instruction_complete = cmp;
    needs_mem = nm;
    illegal_op = ill;
    mem_ready = mr;
    ext_irq = irq;
    trap_return = tr;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input bit use_b, input logic [2:0] exp_state,
                             input logic [1:0] exp_cause, input logic [15:0] exp_cnt);
    logic [2:0] st;
    logic [1:0] tc;
    logic [15:0] rc;
    logic [5:0] stages, exp_stages;
    if (use_b) begin
      st = b_state; tc = b_cause; rc = b_count;
      stages = {b_trap, b_wb, b_mem, b_execute, b_decode, b_fetch};
    end else begin
      st = a_state; tc = a_cause; rc = {12'd0, a_count};
      stages = {a_trap, a_wb, a_mem, a_execute, a_decode, a_fetch};
    end
    exp_stages = 6'b000001 << exp_state;
    checks++;
    if (st !== exp_state) begin
      failures++;
      $display("[TB] FAIL %s state: got %0d required %0d", name, st, exp_state);
    end
    checks++;
    if (stages !== exp_stages) begin
      failures++;
      $display("[TB] FAIL %s stage enables: got %b required %b", name, stages, exp_stages);
    end
    checks++;
    if (tc !== exp_cause) begin
      failures++;
      $display("[TB] FAIL %s trap_cause: got %0d required %0d", name, tc, exp_cause);
    end
    checks++;
    if (rc !== exp_cnt) begin
      failures++;
      $display("[TB] FAIL %s retired_count: got %0d required %0d", name, rc, exp_cnt);
    end
  endtask

  vec_t vecs[40];

  initial begin
    // {rst, cmp, nm, ill, mr, irq, tr, next state, cause, count} for instance a
    vecs[0]  = '{1,0,0,0,0,0,0, S_F,2'd0,4'd0};
    vecs[1]  = '{0,1,0,0,0,0,0, S_D,2'd0,4'd0};
    vecs[2]  = '{0,0,0,0,0,0,0, S_E,2'd0,4'd0};
    vecs[3]  = '{0,0,0,0,0,1,0, S_W,2'd0,4'd0};
    vecs[4]  = '{0,0,0,0,0,0,0, S_F,2'd0,4'd1};
    vecs[5]  = '{0,1,0,0,0,1,0, S_T,2'd1,4'd1};
    vecs[6]  = '{0,0,0,0,0,0,0, S_T,2'd1,4'd1};
    vecs[7]  = '{0,0,0,0,0,0,1, S_F,2'd1,4'd1};
    vecs[8]  = '{0,1,0,0,0,0,1, S_D,2'd1,4'd1};
    vecs[9]  = '{0,0,1,0,0,0,0, S_E,2'd1,4'd1};
    vecs[10] = '{0,0,0,0,0,0,0, S_M,2'd1,4'd1};
    for (int i = 11; i <= 14; i++) vecs[i] = '{0,0,0,0,0,0,0, S_M,2'd1,4'd1};
    vecs[15] = '{0,0,0,0,0,0,0, S_T,2'd2,4'd1};
    vecs[16] = '{0,0,0,0,0,0,1, S_F,2'd2,4'd1};
    vecs[17] = '{0,1,0,0,0,0,0, S_D,2'd2,4'd1};
    vecs[18] = '{0,0,1,1,0,0,0, S_T,2'd0,4'd1};
    vecs[19] = '{0,0,0,0,0,0,1, S_F,2'd0,4'd1};
    for (int i = 20; i <= 23; i++) vecs[i] = '{0,0,0,0,0,0,0, S_F,2'd0,4'd1};
    vecs[24] = '{0,0,0,0,0,0,0, S_T,2'd2,4'd1};
    vecs[25] = '{0,0,0,0,0,0,1, S_F,2'd2,4'd1};
    vecs[26] = '{0,1,0,0,0,0,0, S_D,2'd2,4'd1};
    vecs[27] = '{0,0,1,0,0,0,0, S_E,2'd2,4'd1};
    vecs[28] = '{0,0,0,0,0,0,0, S_M,2'd2,4'd1};
    for (int i = 29; i <= 32; i++) vecs[i] = '{0,0,0,0,0,0,0, S_M,2'd2,4'd1};
    vecs[33] = '{0,0,0,0,1,0,0, S_W,2'd2,4'd1};
    vecs[34] = '{0,0,0,0,0,0,0, S_F,2'd2,4'd2};
    vecs[35] = '{0,1,0,0,0,0,0, S_D,2'd2,4'd2};
    vecs[36] = '{0,0,1,0,0,0,0, S_E,2'd2,4'd2};
    vecs[37] = '{0,0,0,0,1,0,0, S_M,2'd2,4'd2};
    vecs[38] = '{0,0,0,0,1,0,0, S_W,2'd2,4'd2};
    vecs[39] = '{0,0,0,0,0,0,0, S_F,2'd2,4'd3};

    for (int i = 0; i < 40; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].cmp, vecs[i].nm, vecs[i].ill, vecs[i].mr,
                    vecs[i].irq, vecs[i].tr);
      checkOutput($sformatf("vec%0d", i), 1'b0, vecs[i].st, vecs[i].cause, {12'd0, vecs[i].cnt});
    end

    // Retire 12 more on instance a (3 -> 15), then one more wraps to 0.
    for (int n = 0; n < 13; n++) begin
      applyStimulus(0,1,0,0,0,0,0);
      applyStimulus(0,0,0,0,0,0,0);
      applyStimulus(0,0,0,0,0,0,0);
      applyStimulus(0,0,0,0,0,0,0);
      if (n == 11) checkOutput("count_15", 1'b0, S_F, 2'd2, 16'd15);
    end
    checkOutput("count_wrap", 1'b0, S_F, 2'd2, 16'd0);
    applyStimulus(0,1,0,0,0,0,0);
    applyStimulus(0,0,0,0,0,0,0);
    applyStimulus(0,0,0,0,0,0,0);
    applyStimulus(0,0,0,0,0,0,0);
    checkOutput("count_after_wrap", 1'b0, S_F, 2'd2, 16'd1);
    applyStimulus(0,1,0,0,0,0,0);
    applyStimulus(0,0,0,0,0,0,0);
    checkOutput("pre_reset_exec", 1'b0, S_E, 2'd2, 16'd1);
    applyStimulus(1,1,1,1,1,1,1);
    checkOutput("reset_in_exec", 1'b0, S_F, 2'd0, 16'd0);

    // Instance b: EXEC_CYCLES=3 with memory, mem_ready on the third MEM cycle.
    applyStimulus(0,1,0,0,0,0,0); checkOutput("b_decode", 1'b1, S_D, 2'd0, 16'd0);
    applyStimulus(0,0,1,0,0,0,0); checkOutput("b_exec0", 1'b1, S_E, 2'd0, 16'd0);
    applyStimulus(0,0,0,0,0,0,0); checkOutput("b_exec1", 1'b1, S_E, 2'd0, 16'd0);
    applyStimulus(0,0,0,0,0,0,0); checkOutput("b_exec2", 1'b1, S_E, 2'd0, 16'd0);
    applyStimulus(0,0,0,0,0,0,0); checkOutput("b_mem0", 1'b1, S_M, 2'd0, 16'd0);
    applyStimulus(0,0,0,0,0,0,0); checkOutput("b_mem1", 1'b1, S_M, 2'd0, 16'd0);
    applyStimulus(0,0,0,0,0,0,0); checkOutput("b_mem2", 1'b1, S_M, 2'd0, 16'd0);
    applyStimulus(0,0,0,0,1,0,0); checkOutput("b_wb", 1'b1, S_W, 2'd0, 16'd0);
    applyStimulus(0,0,0,0,0,0,0); checkOutput("b_retire", 1'b1, S_F, 2'd0, 16'd1);

    // Instance b without memory: FETCH back to FETCH in 3+EXEC_CYCLES cycles.
    applyStimulus(0,1,0,0,0,0,0);
    applyStimulus(0,0,0,0,0,0,0);
    applyStimulus(0,0,0,0,0,0,0);
    applyStimulus(0,0,0,0,0,0,0);
    applyStimulus(0,0,0,0,0,0,0); checkOutput("b_nomem_wb", 1'b1, S_W, 2'd0, 16'd1);
    applyStimulus(0,0,0,0,0,0,0); checkOutput("b_nomem_fetch", 1'b1, S_F, 2'd0, 16'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
